// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave exposing REG_COUNT 32-bit byte-writable registers.
// Independent write (AW/W/B) and read (AR/R) state machines; out-of-range indices answer SLVERR.
module axi4lite_slave_regs #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 4
) (
  input  logic                      aclk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axi4lite_slave_regs supports DATA_WIDTH = 32 only");
  end

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Register file
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

  // Write channel state
  w_state_e              w_state_q, w_state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q,  w_done_d;
  logic [IDX_W-1:0]      aw_idx_q,  aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q,  wready_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;

  // Read channel state
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic [IDX_W-1:0]      ar_idx;

  // Byte offset bits carry no meaning for word registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < REG_COUNT;
  endfunction

  assign aw_hs  = AWVALID && awready_q;
  assign w_hs   = WVALID && wready_q;
  assign ar_hs  = ARVALID && arready_q;
  assign ar_idx = ARADDR[ADDR_WIDTH-1:2];

  // Write FSM: capture AW and W independently, commit once both are held.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;

    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          aw_idx_d  = AWADDR[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        if (aw_done_d && w_done_d) begin
          for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (32'(aw_idx_d) == i) begin
              for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb_d[b]) begin
                  regs_d[i][8*b +: 8] = wdata_d[8*b +: 8];
                end
              end
            end
          end
          bresp_d   = idx_in_range(aw_idx_d) ? RESP_OKAY : RESP_SLVERR;
          bvalid_d  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          awready_d = !aw_done_d;
          wready_d  = !w_done_d;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: sample the register file as it stands before this edge's write.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d = '0;
          for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (32'(ar_idx) == i) begin
              rdata_d = regs_q[i];
            end
          end
          rresp_d   = idx_in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      regs_q    <= regs_d;
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Randomised self-checking bench for axi4lite_slave_regs (REG_COUNT = 3 so index 3 is out of range).
module tb_axi4lite_slave_regs;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned RC = 3;

  logic          aclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] AWADDR = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;
  logic [AW-1:0] ARADDR = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [4];

  axi4lite_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
    .aclk(aclk), .rst_n(rst_n),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 aclk = ~aclk;

  // Reference model: word index = addr / 4, indices >= RC are errors.
  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    int idx = int'(a) / 4;
    return (idx < int'(RC)) ? model[idx] : 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [AW-1:0] a);
    return ((int'(a) / 4) < int'(RC)) ? 2'b00 : 2'b10;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a) / 4;
    if (idx < int'(RC)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
  endfunction

  // Drives AW and W with independent start delays; returns edges from commit to BVALID.
  task automatic drv_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, output bit ok, output int lat);
    int  cyc = 0;
    bit  awd = 0, wd = 0, awh, wh;
    AWADDR = a; WDATA = d; WSTRB = s;
    while (!(awd && wd) && cyc < 64) begin
      AWVALID = !awd && (cyc >= aw_dly);
      WVALID  = !wd && (cyc >= w_dly);
      @(negedge aclk);
      awh = AWVALID && AWREADY;
      wh  = WVALID && WREADY;
      @(posedge aclk); #1;
      awd |= awh; wd |= wh; cyc++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    ok  = awd && wd;
    lat = 1;
    while (!BVALID && lat < 16) begin
      @(posedge aclk); #1;
      lat++;
    end
  endtask

  // Holds BREADY low for 'hold' cycles (optionally offering a stray AW), then completes B.
  task automatic drv_bresp(input int hold, input bit poke, output logic [1:0] resp,
                           output bit stable, output bit rdy_low);
    logic [1:0] r0 = BRESP;
    stable = BVALID; rdy_low = 1;
    if (poke) begin AWADDR = 4'h4; AWVALID = 1'b1; end
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      if (!(BVALID === 1'b1 && BRESP === r0)) stable = 0;
      if (!(AWREADY === 1'b0 && WREADY === 1'b0)) rdy_low = 0;
      @(posedge aclk); #1;
    end
    BREADY = 1'b1;
    @(negedge aclk);
    if (!(BVALID === 1'b1 && BRESP === r0)) stable = 0;
    @(posedge aclk); #1;
    BREADY = 1'b0; AWVALID = 1'b0;
    resp = r0;
  endtask

  // Issues AR, holds RREADY low for 'hold' cycles, then completes R.
  task automatic drv_read(input logic [AW-1:0] a, input int hold, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok, output bit stable);
    int cyc = 0;
    bit h = 0;
    ARADDR = a; ARVALID = 1'b1;
    while (!h && cyc < 64) begin
      @(negedge aclk);
      h = ARREADY;
      @(posedge aclk); #1;
      cyc++;
    end
    ARVALID = 1'b0;
    ok = h && RVALID;
    data = RDATA; resp = RRESP; stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      if (!(RVALID === 1'b1 && RDATA === data && RRESP === resp && ARREADY === 1'b0)) stable = 0;
      @(posedge aclk); #1;
    end
    RREADY = 1'b1;
    @(posedge aclk); #1;
    RREADY = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0 || BRESP !== 2'b00 ||
        RRESP !== 2'b00 || RDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h, expected all zero",
               AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA);
    end
    @(negedge aclk);
    rst_n = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset: got %b%b%b, expected 111", AWREADY, WREADY, ARREADY);
    end
    model_clear();
  endtask

  task automatic test_same_cycle_write();
    bit ok, st, rl; int lat; logic [1:0] resp; logic [31:0] d;
    drv_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 0, ok, lat);
    checks++;
    if (!ok || lat != 1) begin
      errors++;
      $display("FAIL same_cycle_latency: ok=%0d lat=%0d, expected ok=1 lat=1", ok, lat);
    end
    drv_bresp(0, 0, resp, st, rl);
    model_write(4'h4, 32'hDEADBEEF, 4'hF);
    checks++;
    if (resp !== 2'b00) begin
      errors++;
      $display("FAIL same_cycle_bresp: got %b, expected 00", resp);
    end
    drv_read(4'h4, 0, d, resp, ok, st);
    checks++;
    if (!ok || d !== 32'hDEADBEEF || resp !== 2'b00) begin
      errors++;
      $display("FAIL same_cycle_readback: ok=%0d data=%h resp=%b, expected deadbeef 00", ok, d, resp);
    end
  endtask

  task automatic test_w_before_aw();
    bit ok, st, rl; int lat; logic [1:0] resp; logic [31:0] d;
    drv_write(4'h8, 32'h11223344, 4'h5, 3, 0, ok, lat);
    checks++;
    if (!ok || lat != 1) begin
      errors++;
      $display("FAIL w_first_latency: ok=%0d lat=%0d, expected ok=1 lat=1", ok, lat);
    end
    drv_bresp(0, 0, resp, st, rl);
    model_write(4'h8, 32'h11223344, 4'h5);
    drv_read(4'h8, 2, d, resp, ok, st);
    checks++;
    if (!ok || !st || d !== 32'h00220044 || resp !== 2'b00) begin
      errors++;
      $display("FAIL w_first_readback: ok=%0d stable=%0d data=%h resp=%b, expected 00220044 00", ok, st, d, resp);
    end
  endtask

  task automatic test_bresp_hold();
    bit ok, st, rl; int lat; logic [1:0] resp; logic [31:0] d;
    drv_write(4'h0, 32'h0BADF00D, 4'hF, 0, 0, ok, lat);
    drv_bresp(5, 1, resp, st, rl);
    model_write(4'h0, 32'h0BADF00D, 4'hF);
    checks++;
    if (!ok || !st || !rl || resp !== 2'b00) begin
      errors++;
      $display("FAIL bresp_hold: ok=%0d stable=%0d ready_low=%0d resp=%b, expected 1 1 1 00", ok, st, rl, resp);
    end
    // A stray AW accepted during W_RESP would redirect this write to index 1.
    drv_write(4'h0, 32'h12345678, 4'hF, 0, 0, ok, lat);
    drv_bresp(0, 0, resp, st, rl);
    model_write(4'h0, 32'h12345678, 4'hF);
    for (int a = 0; a < 8; a += 4) begin
      drv_read(AW'(a), 0, d, resp, ok, st);
      checks++;
      if (d !== model_read(AW'(a))) begin
        errors++;
        $display("FAIL bresp_hold_no_stray_aw: addr=%0h data=%h, expected %h", a, d, model_read(AW'(a)));
      end
    end
  endtask

  task automatic test_slverr();
    bit ok, st, rl; int lat; logic [1:0] resp; logic [31:0] d;
    drv_write(4'hC, 32'hCAFEF00D, 4'hF, 1, 0, ok, lat);
    drv_bresp(1, 0, resp, st, rl);
    checks++;
    if (!ok || resp !== 2'b10) begin
      errors++;
      $display("FAIL slverr_bresp: ok=%0d resp=%b, expected 10", ok, resp);
    end
    drv_read(4'hC, 1, d, resp, ok, st);
    checks++;
    if (!ok || d !== 32'h0 || resp !== 2'b10) begin
      errors++;
      $display("FAIL slverr_read: data=%h resp=%b, expected 0 10", d, resp);
    end
    drv_read(4'h8, 0, d, resp, ok, st);
    checks++;
    if (d !== model_read(4'h8) || resp !== 2'b00) begin
      errors++;
      $display("FAIL slverr_reg2_intact: data=%h resp=%b, expected %h 00", d, resp, model_read(4'h8));
    end
  endtask

  task automatic test_strb_zero();
    bit ok, st, rl; int lat; logic [1:0] resp; logic [31:0] d;
    drv_write(4'h4, 32'hFFFFFFFF, 4'h0, 0, 2, ok, lat);
    drv_bresp(0, 0, resp, st, rl);
    drv_read(4'h4, 0, d, resp, ok, st);
    checks++;
    if (d !== model_read(4'h4) || resp !== 2'b00) begin
      errors++;
      $display("FAIL strb_zero: data=%h resp=%b, expected %h 00", d, resp, model_read(4'h4));
    end
  endtask

  task automatic test_same_edge_rw();
    bit ok, st, rl, h; int lat; logic [1:0] resp; logic [31:0] d;
    drv_write(4'h0, 32'h00000001, 4'hF, 0, 0, ok, lat);
    drv_bresp(0, 0, resp, st, rl);
    model_write(4'h0, 32'h00000001, 4'hF);
    AWADDR = 4'h0; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; ARADDR = 4'h0;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    @(negedge aclk);
    h = AWREADY && WREADY && ARREADY;
    @(posedge aclk); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    checks++;
    if (!h || BVALID !== 1'b1 || RVALID !== 1'b1 || RDATA !== 32'h1) begin
      errors++;
      $display("FAIL same_edge_rw: hs=%0d bvalid=%b rvalid=%b rdata=%h, expected 1 1 1 00000001", h, BVALID, RVALID, RDATA);
    end
    model_write(4'h0, 32'hA5A5A5A5, 4'hF);
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge aclk); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    drv_read(4'h0, 0, d, resp, ok, st);
    checks++;
    if (d !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL same_edge_followup: data=%h, expected a5a5a5a5", d);
    end
  endtask

  task automatic test_random();
    bit ok, st, rl; int lat; logic [1:0] resp; logic [31:0] d, wd;
    logic [AW-1:0] a; logic [3:0] s;
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom_range(0, 15)); wd = $urandom; s = 4'($urandom_range(0, 15));
      drv_write(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), ok, lat);
      drv_bresp($urandom_range(0, 3), 0, resp, st, rl);
      checks++;
      if (!ok || lat != 1 || !st || resp !== model_resp(a)) begin
        errors++;
        $display("FAIL rand_write[%0d]: addr=%h ok=%0d lat=%0d stable=%0d resp=%b, expected resp %b", n, a, ok, lat, st, resp, model_resp(a));
      end
      model_write(a, wd, s);
      a = AW'($urandom_range(0, 15));
      drv_read(a, $urandom_range(0, 3), d, resp, ok, st);
      checks++;
      if (!ok || !st || d !== model_read(a) || resp !== model_resp(a)) begin
        errors++;
        $display("FAIL rand_read[%0d]: addr=%h ok=%0d stable=%0d data=%h resp=%b, expected %h %b", n, a, ok, st, d, resp, model_read(a), model_resp(a));
      end
    end
  endtask

  task automatic test_reset_pending();
    bit ok, st, h; int lat; logic [1:0] resp; logic [31:0] d;
    drv_write(4'h4, 32'h55AA55AA, 4'hF, 0, 0, ok, lat);
    ARADDR = 4'h8; ARVALID = 1'b1;
    @(negedge aclk);
    h = ARREADY;
    @(posedge aclk); #1;
    ARVALID = 1'b0;
    checks++;
    if (!h || RVALID !== 1'b1 || BVALID !== 1'b1) begin
      errors++;
      $display("FAIL pending_before_reset: ar=%0d rvalid=%b bvalid=%b, expected 1 1 1", h, RVALID, BVALID);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (RVALID !== 1'b0 || BVALID !== 1'b0 || RDATA !== 32'h0 || ARREADY !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rvalid=%b bvalid=%b rdata=%h arready=%b, expected 0 0 0 0", RVALID, BVALID, RDATA, ARREADY);
    end
    model_clear();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    rst_n = 1'b1;
    @(posedge aclk); #1;
    for (int a = 0; a < 16; a += 4) begin
      drv_read(AW'(a), 0, d, resp, ok, st);
      checks++;
      if (!ok || d !== 32'h0 || resp !== model_resp(AW'(a))) begin
        errors++;
        $display("FAIL post_reset_read: addr=%0h data=%h resp=%b, expected 0 %b", a, d, resp, model_resp(AW'(a)));
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_bresp_hold();
    test_slverr();
    test_strb_zero();
    test_same_edge_rw();
    test_random();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
